fwrisc_mem_arbiter: RTL
=======================

# fwrisc_mem_arbiter

Shares one single-ported memory bus between the fwrisc instruction-fetch port and data port. It sits between the core (PC/ivalid/iready and dvalid/daddr/dready) and a unified SRAM or bus bridge. Each transaction is registered and sequenced by a small state machine. Data accesses win by default, and an optional anti-starvation counter guarantees forward progress for fetch. A core flush discards an in-flight fetch response.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits; range 1–15. Used only with fairness compiled in.
- clock in 1: single clock; all state changes on its rising edge.
- reset_n in 1: asynchronous, active-low reset.
- i_addr in 32: fetch address (core PC).
- i_valid in 1: fetch request; held until i_ready.
- i_ready out 1: one-cycle fetch completion pulse.
- i_rdata out 32: fetch data; valid while i_ready is 1.
- d_addr in 32: data address.
- d_wdata in 32: store data.
- d_wstb in 4: store byte strobes.
- d_write in 1: 1 means store, 0 means load.
- d_valid in 1: data request; held until d_ready.
- d_ready out 1: one-cycle data completion pulse.
- d_rdata out 32: load data; valid while d_ready is 1.
- flush in 1: core pipeline flush (branch taken).
- m_valid out 1: memory request.
- m_addr out 32: memory address.
- m_wdata out 32: memory write data.
- m_wstb out 4: memory byte strobes; 0 for fetch.
- m_write out 1: memory write enable.
- m_rdata in 32: memory read data.
- m_ready in 1: memory completion; sampled only while m_valid is 1.
- owner out 2: current state encoding, for debug.

## Operation
- States and owner encoding: IDLE=0, I_BUSY=1, D_BUSY=2, RESP=3.
- IDLE:
  - Only d_valid: go to D_BUSY.
  - Only i_valid: go to I_BUSY.
  - Both: go to D_BUSY, unless the starve counter equals STARVE_LIMIT (fairness only), then go to I_BUSY.
  - Neither: stay in IDLE.
- Grant edge: m_addr, m_wdata, m_wstb and m_write are latched from the winner.
  - Fetch grant: m_wstb=0, m_write=0.
  - Request inputs are ignored after the grant until the next IDLE.
- I_BUSY / D_BUSY: m_valid=1, bus outputs stable.
  - When m_ready=1: capture m_rdata into the owner's rdata register, pulse the owner's ready on the next cycle, go to RESP.
- RESP:
  - m_valid=0, the owner's ready is 1 for exactly this cycle, no arbitration takes place.
  - Next state is IDLE. This prevents re-granting a request the core has not yet dropped.
- Flush:
  - flush=1 in any cycle of I_BUSY, including the m_ready cycle, sets drop.
  - The memory transaction still completes. In RESP i_ready stays 0 and i_rdata is not updated. drop clears on leaving RESP.
  - flush in IDLE or RESP, or during D_BUSY, has no effect.
- Starve counter (4 bits):
  - Increments on each D grant made while i_valid=1; saturates at STARVE_LIMIT.
  - Clears on each I grant.
- Loads and stores are treated identically; m_rdata is captured on stores but d_rdata content is don't-care.

## Timing
- Reset (asynchronous, while reset_n=0):
  - state=IDLE; all outputs 0 (m_valid, m_addr, m_wdata, m_wstb, m_write, i_ready, i_rdata, d_ready, d_rdata, owner).
  - Starve counter and drop are 0.
  - Reset asserted mid-transaction abandons it immediately; m_valid drops without waiting for m_ready.
- Minimum latency, with the request at cycle 0:
  - m_valid=1 at cycle 1.
  - m_ready at cycle k≥1 gives ready at cycle k+1; IDLE at k+2.
  - Zero-wait memory: 3 cycles per access, back-to-back.
- i_ready/d_ready are never high together, and never high for more than one cycle per transaction.
- Simultaneous flush and m_ready in I_BUSY: the response is dropped.

## Configuration
- FWRISC_MEM_ARB_FAIRNESS_EN defined: starve counter and STARVE_LIMIT override are active.
- Undefined: strict data priority; the counter logic is absent, and a continuous d_valid stream may starve fetch indefinitely.

## Test plan
- Reset: drive reset_n=0 mid-D_BUSY with m_ready=0 → all outputs 0 asynchronously; after release, owner=0.
- Lone fetch: i_valid with i_addr=0x100, memory returns 0x00000013 at k=1 → m_valid at cycle 1, i_ready=1 and i_rdata=0x13 at cycle 2, m_wstb=0.
- Store with wait states: d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstb=0xF, m_ready at cycle 4 → m_write=1 and bus stable cycles 1–4, d_ready=1 at cycle 5 only.
- Contention: i_valid and d_valid both high at cycle 0 → D wins; I is granted at cycle 3 after RESP/IDLE.
- Starvation, fairness defined, STARVE_LIMIT=2: d_valid and i_valid held high → grant order D, D, I, D, D, I. With the macro undefined → D only.
- Flush: fetch at 0x40, flush=1 at cycle 1, m_ready at cycle 2 → no i_ready pulse and i_rdata unchanged; the next fetch to 0x80 completes normally.

Source files
------------

// File: rtl/fwrisc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fwrisc_mem_arbiter
// Purpose  : Shares one single-ported memory bus between the fwrisc fetch port
//            and data port. One transaction at a time, sequenced by a
//            four-state machine: IDLE -> I_BUSY/D_BUSY -> RESP -> IDLE.
//            Data requests win by default. A core flush during a fetch
//            discards that fetch's response.
// Ports    : clock, reset_n          - clock, async active-low reset
//            i_addr/i_valid          - fetch request (in)
//            i_ready/i_rdata         - fetch completion pulse + data (out)
//            d_addr/d_wdata/d_wstb/
//            d_write/d_valid         - data request (in)
//            d_ready/d_rdata         - data completion pulse + data (out)
//            flush                   - core pipeline flush (in)
//            m_valid/m_addr/m_wdata/
//            m_wstb/m_write          - memory request (out)
//            m_rdata/m_ready         - memory response (in)
//            owner                   - state encoding for debug (out)
// Options  : FWRISC_MEM_ARB_FAIRNESS_EN - when defined, a starve counter lets
//            a waiting fetch win after STARVE_LIMIT consecutive data grants.
// Revision : 1.0 - initial release
// ============================================================================
module fwrisc_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] i_addr,
  input  logic        i_valid,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstb,
  input  logic        d_write,
  input  logic        d_valid,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  input  logic        flush,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstb,
  output logic        m_write,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_BUSY = 2'd1,
    ST_D_BUSY = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // The counter is 4 bits wide, so the limit must fit in 1..15.
  generate
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_bad
      $error("fwrisc_mem_arbiter: STARVE_LIMIT must be in 1..15");
    end
  endgenerate

  state_e      state_q, state_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstb_q, m_wstb_d;
  logic        m_write_q, m_write_d;
  logic        i_ready_q, i_ready_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        drop_q, drop_d;
  logic        grant_d;
  logic        grant_i;

`ifdef FWRISC_MEM_ARB_FAIRNESS_EN
  logic [3:0]  starve_q, starve_d;
  logic        starve_hit;

  assign starve_hit = (starve_q == 4'(STARVE_LIMIT));
  // Data wins unless a waiting fetch has already been passed over the limit.
  assign grant_d    = d_valid && !(i_valid && starve_hit);
`else
  assign grant_d    = d_valid;
`endif
  assign grant_i    = i_valid && !grant_d;

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstb_d  = m_wstb_q;
    m_write_d = m_write_q;
    i_ready_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_ready_d = 1'b0;
    d_rdata_d = d_rdata_q;
    drop_d    = drop_q;
`ifdef FWRISC_MEM_ARB_FAIRNESS_EN
    starve_d  = starve_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d   = ST_D_BUSY;
          m_valid_d = 1'b1;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_wstb_d  = d_wstb;
          m_write_d = d_write;
`ifdef FWRISC_MEM_ARB_FAIRNESS_EN
          if (i_valid && !starve_hit) starve_d = starve_q + 4'd1;
`endif
        end else if (grant_i) begin
          state_d   = ST_I_BUSY;
          m_valid_d = 1'b1;
          m_addr_d  = i_addr;
          m_wdata_d = 32'd0;
          m_wstb_d  = 4'd0;
          m_write_d = 1'b0;
`ifdef FWRISC_MEM_ARB_FAIRNESS_EN
          starve_d  = 4'd0;
`endif
        end
      end
      ST_I_BUSY: begin
        if (flush) drop_d = 1'b1;
        if (m_ready) begin
          state_d   = ST_RESP;
          m_valid_d = 1'b0;
          // A flush in the completing cycle also kills the response.
          if (!(drop_q || flush)) begin
            i_ready_d = 1'b1;
            i_rdata_d = m_rdata;
          end
        end
      end
      ST_D_BUSY: begin
        if (m_ready) begin
          state_d   = ST_RESP;
          m_valid_d = 1'b0;
          d_ready_d = 1'b1;
          d_rdata_d = m_rdata;
        end
      end
      default: begin
        // RESP: one dead cycle so a request still held high by the core
        // (it only just saw ready) is not granted a second time.
        state_d = ST_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      m_valid_q <= 1'b0;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
      m_wstb_q  <= 4'd0;
      m_write_q <= 1'b0;
      i_ready_q <= 1'b0;
      i_rdata_q <= 32'd0;
      d_ready_q <= 1'b0;
      d_rdata_q <= 32'd0;
      drop_q    <= 1'b0;
`ifdef FWRISC_MEM_ARB_FAIRNESS_EN
      starve_q  <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstb_q  <= m_wstb_d;
      m_write_q <= m_write_d;
      i_ready_q <= i_ready_d;
      i_rdata_q <= i_rdata_d;
      d_ready_q <= d_ready_d;
      d_rdata_q <= d_rdata_d;
      drop_q    <= drop_d;
`ifdef FWRISC_MEM_ARB_FAIRNESS_EN
      starve_q  <= starve_d;
`endif
    end
  end

  assign m_valid = m_valid_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstb  = m_wstb_q;
  assign m_write = m_write_q;
  assign i_ready = i_ready_q;
  assign i_rdata = i_rdata_q;
  assign d_ready = d_ready_q;
  assign d_rdata = d_rdata_q;
  assign owner   = state_q;

endmodule
`default_nettype wire
